program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: MAX_WORDS, 32768, instruction ROM depth in words; largest accepted program length.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  incoming byte from serial front end.
REQ-005 rx_valid  input  1  rx_data holds a byte.
REQ-006 rx_ready  output  1  loader can take a byte; a byte transfers on a clk edge where rx_valid and rx_ready are both 1.
REQ-007 rom_write  output  1  one-cycle write strobe to the instruction ROM write port.
REQ-008 rom_address  output  15  ROM word address for rom_write.
REQ-009 rom_data  output  16  ROM word for rom_write.
REQ-010 cpu_reset  output  1  active-high reset to the CPU; holds CPU at pc 0 while 1.
REQ-011 done  output  1  one-cycle pulse on a successful load.
REQ-012 error  output  1  sticky flag for the last load failing.

Function
REQ-013 The frame SHALL be: header 0xA5; length N as 2 bytes, big-endian, in words; N words, each high byte then low byte; 1 checksum byte.
REQ-014 The checksum SHALL be the XOR of all 2N word bytes; it excludes header and length; it is 0x00 for N=0.
REQ-015 States SHALL be IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, WRITE, CHECK, RUN.
REQ-016 In IDLE, 0xA5 SHALL go to LEN_HI and clear error; any other byte is discarded.
REQ-017 LEN_HI SHALL store the high length byte and go to LEN_LO.
REQ-018 LEN_LO SHALL store the low length byte.
  - N > MAX_WORDS: set error, go to IDLE.
  - N = 0: go to CHECK.
  - Otherwise: go to WORD_HI.
REQ-019 Accepting the low byte in WORD_LO SHALL go to WRITE.
REQ-020 WRITE SHALL last exactly one cycle.
  - rom_write=1, rom_data={hi,lo}, rom_address = current word index.
  - rx_ready=0.
REQ-021 After WRITE, the word index SHALL increment; when it equals N, go to CHECK, else go to WORD_HI.
REQ-022 The first word of every frame SHALL be written to address 0.
  - Addresses SHALL increase by 1 per word, with no gaps.
  - rom_address SHALL never exceed MAX_WORDS-1.
REQ-023 On a matching checksum, CHECK SHALL go to RUN.
  - Next cycle: cpu_reset=0 and done=1 for exactly that cycle.
REQ-024 On a mismatching checksum, CHECK SHALL go to IDLE.
  - Next cycle: error=1; cpu_reset stays 1.
REQ-025 rx_ready SHALL be 1 in every state except WRITE.
REQ-026 In RUN, 0xA5 SHALL set cpu_reset=1 on the next cycle and go to LEN_HI (reload); any other byte is discarded.
REQ-027 cpu_reset SHALL be 1 in every state except RUN.
REQ-028 rom_write SHALL be 0 outside WRITE; rom_address and rom_data are don't-care when rom_write=0.
REQ-029 rx_valid=0 in any state SHALL cause no state change, except WRITE advancing (REQ-021).
REQ-030 Gaps of any length between bytes SHALL be tolerated; there is no timeout.

Reset
REQ-031 reset_n=0 SHALL immediately force, independent of clk:
  - state IDLE
  - cpu_reset=1, rom_write=0, done=0, error=0
  - word index and checksum cleared
REQ-032 reset_n asserted mid-frame SHALL abandon the frame.
  - Words already written stay in ROM.
  - After release, the loader waits for a new 0xA5.
REQ-033 Outputs after reset_n release SHALL change only on clk edges.

Verification
REQ-034 Reset then idle -> cpu_reset=1, rx_ready=1, rom_write=0, done=0, error=0.
REQ-035 Stream A5 00 02 12 34 AB CD 40 (checksum 12^34^AB^CD=0x40) -> expected response:
  - rom_write pulses: (addr 0, 0x1234), then (addr 1, 0xABCD).
  - rx_ready low on each write cycle.
  - done pulse one cycle after the checksum byte, with cpu_reset falling on that same cycle.
REQ-036 Same frame with checksum byte 41 -> two writes occur, then error=1 and cpu_reset stays 1, with no done pulse.
REQ-037 A5 00 00 00 -> no rom_write, done pulse, cpu_reset=0.
REQ-038 With MAX_WORDS=4, stream A5 00 05 -> error=1 after the length byte, no rom_write, state IDLE.
  - A following valid frame loads normally and clears error.
REQ-039 In RUN, send stray 0x00 then A5 00 01 FF FF 00 -> expected response:
  - 0x00 ignored.
  - cpu_reset=1 one cycle after A5.
  - Write (addr 0, 0xFFFF).
  - done; cpu_reset returns to 0.
  - Also: reset_n pulsed after the first word byte -> IDLE, no write.

Source files
------------

// File: rtl/program_loader.sv
// Purpose: receives a framed program over a byte stream, writes it into the instruction ROM and releases the CPU.
// Latency: each ROM write follows one cycle after its low byte; done/error follow one cycle after the checksum byte.
// Backpressure: rx_ready drops only during the single ROM write cycle; input gaps of any length are tolerated.
module program_loader #(
    parameter int MAX_WORDS = 32768
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        rom_write,
    output logic [14:0] rom_address,
    output logic [15:0] rom_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, WRITE, CHECK, RUN
    } state_t;

    localparam logic [7:0]  HDR_BYTE = 8'hA5;
    localparam logic [16:0] MAX_LEN  = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [7:0]  word_hi;
    logic [7:0]  word_lo;
    logic [7:0]  csum;
    logic        done_q;
    logic        error_q;

    logic        accept;
    logic        is_hdr;
    logic [15:0] len_in;
    logic        too_long;
    logic        last_word;
    logic        csum_ok;

    assign accept    = rx_valid && rx_ready;
    assign is_hdr    = (rx_data == HDR_BYTE);
    assign len_in    = {len_hi, rx_data};
    assign too_long  = ({1'b0, len_in} > MAX_LEN);
    assign last_word = ((word_idx + 16'd1) == len);
    assign csum_ok   = (rx_data == csum);

    // Outputs decoded purely from registered state so they only move on clk edges.
    assign rx_ready    = (state != WRITE);
    assign rom_write   = (state == WRITE);
    assign cpu_reset   = (state != RUN);
    assign rom_address = word_idx[14:0];
    assign rom_data    = {word_hi, word_lo};
    assign done        = done_q;
    assign error       = error_q;

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode: only an accepted byte moves the FSM, except WRITE which always advances.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_hdr) state_nxt = LEN_HI;
            LEN_HI:  if (accept) state_nxt = LEN_LO;
            LEN_LO:  if (accept) begin
                         if (too_long)            state_nxt = IDLE;
                         else if (len_in == 16'd0) state_nxt = CHECK;
                         else                     state_nxt = WORD_HI;
                     end
            WORD_HI: if (accept) state_nxt = WORD_LO;
            WORD_LO: if (accept) state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? CHECK : WORD_HI;
            CHECK:   if (accept) state_nxt = csum_ok ? RUN : IDLE;
            RUN:     if (accept && is_hdr) state_nxt = LEN_HI;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame datapath: length capture, word assembly, running XOR, and done/error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_hi   <= '0;
            len      <= '0;
            word_idx <= '0;
            word_hi  <= '0;
            word_lo  <= '0;
            csum     <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (accept && is_hdr) begin
                    error_q  <= 1'b0;
                    word_idx <= '0;
                    csum     <= '0;
                end
                RUN: if (accept && is_hdr) begin
                    word_idx <= '0;
                    csum     <= '0;
                end
                LEN_HI: if (accept) len_hi <= rx_data;
                LEN_LO: if (accept) begin
                    len <= len_in;
                    if (too_long) error_q <= 1'b1;
                end
                WORD_HI: if (accept) begin
                    word_hi <= rx_data;
                    csum    <= csum ^ rx_data;
                end
                WORD_LO: if (accept) begin
                    word_lo <= rx_data;
                    csum    <= csum ^ rx_data;
                end
                WRITE: word_idx <= word_idx + 16'd1;
                CHECK: if (accept) begin
                    if (csum_ok) done_q  <= 1'b1;
                    else         error_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Purpose: self-checking bench for program_loader using a ROM-write scoreboard plus direct flag checks.
// Latency: flags are sampled 1 time unit after the clock edge that transfers the relevant byte.
// Backpressure: the byte driver holds rx_valid until rx_ready is seen, with a bounded wait.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rom_write;
    logic [14:0] rom_address;
    logic [15:0] rom_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_err = 0;

    logic [30:0] exp_q[$];
    logic [30:0] exp_e;
    logic [15:0] words_q[$];

    program_loader #(.MAX_WORDS(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rom_write   (rom_write),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .cpu_reset   (cpu_reset),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one byte and return 1 time unit after the edge that transfers it.
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_ready_timeout", rx_ready, 1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic push_write(input int addr, input logic [15:0] w);
        exp_q.push_back({15'(addr), w});
    endtask

    // Send a complete frame built from words_q; flip perturbs the checksum byte.
    task automatic send_frame(input logic [7:0] flip);
        logic [7:0]  x = 8'h00;
        logic [15:0] n = 16'(words_q.size());
        send(8'hA5);
        send(n[15:8]);
        send(n[7:0]);
        for (int i = 0; i < words_q.size(); i++) begin
            push_write(i, words_q[i]);
            x = x ^ words_q[i][15:8] ^ words_q[i][7:0];
            send(words_q[i][15:8]);
            send(words_q[i][7:0]);
        end
        send(x ^ flip);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ROM write must match the oldest expected (address, word) pair.
    always @(negedge clk) begin
        if (reset_n && rom_write) begin
            check("wr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                check("wr_addr", 32'(rom_address), 32'(exp_e[30:16]));
                check("wr_data", 32'(rom_data), 32'(exp_e[15:0]));
            end
            check("wr_rx_ready", 32'(rx_ready), 0);
        end
    end

    initial begin
        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #3;
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_rom_write", rom_write, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(4);
        check("idle_cpu_reset", cpu_reset, 1);
        check("idle_rx_ready", rx_ready, 1);
        check("idle_rom_write", rom_write, 0);
        check("idle_done", done, 0);
        check("idle_error", error, 0);

        // Two-word frame with good checksum (0x40).
        words_q = '{16'h1234, 16'hABCD};
        send_frame(8'h00);
        check("ok_done", done, 1);
        check("ok_cpu_reset", cpu_reset, 0);
        check("ok_error", error, 0);
        idle_cycles(1);
        check("ok_done_pulse", done, 0);
        check("ok_cpu_run", cpu_reset, 0);
        check("ok_drained", exp_q.size(), 0);

        // Same frame, checksum 0x41: writes still happen, then error.
        send_frame(8'h01);
        check("bad_error", error, 1);
        check("bad_cpu_reset", cpu_reset, 1);
        check("bad_done", done, 0);
        idle_cycles(3);
        check("bad_error_sticky", error, 1);
        check("bad_drained", exp_q.size(), 0);

        // Empty program.
        words_q = {};
        send_frame(8'h00);
        check("empty_done", done, 1);
        check("empty_cpu_reset", cpu_reset, 0);
        check("empty_error_clr", error, 0);

        // Stray byte in RUN, then reload one word 0xFFFF.
        send(8'h00);
        idle_cycles(2);
        check("run_stray_cpu", cpu_reset, 0);
        send(8'hA5);
        check("reload_cpu_reset", cpu_reset, 1);
        send(8'h00);
        send(8'h01);
        push_write(0, 16'hFFFF);
        send(8'hFF);
        send(8'hFF);
        send(8'h00);
        check("reload_done", done, 1);
        check("reload_cpu_run", cpu_reset, 0);
        check("reload_drained", exp_q.size(), 0);

        // Over-length frame with MAX_WORDS=4.
        send(8'hA5);
        send(8'h00);
        send(8'h05);
        idle_cycles(1);
        check("long_error", error, 1);
        check("long_cpu_reset", cpu_reset, 1);
        send(8'h12);
        send(8'h00);
        idle_cycles(3);
        check("long_no_write", exp_q.size(), 0);
        check("long_still_err", error, 1);

        // Boundary: exactly MAX_WORDS words, addresses 0..3.
        words_q = '{16'h0001, 16'h0203, 16'h0405, 16'h0607};
        send_frame(8'h00);
        check("max_done", done, 1);
        check("max_error_clr", error, 0);
        check("max_drained", exp_q.size(), 0);

        // Reset mid-frame after the first word byte.
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        send(8'h12);
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        check("mid_rst_cpu", cpu_reset, 1);
        check("mid_rst_wr", rom_write, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h34);
        send(8'h00);
        idle_cycles(4);
        check("mid_rst_no_write", exp_q.size(), 0);
        check("mid_rst_cpu_held", cpu_reset, 1);
        words_q = '{16'h5678};
        send_frame(8'h00);
        check("after_rst_done", done, 1);
        check("after_rst_drained", exp_q.size(), 0);

        idle_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
